// File: rtl/cpu_pkg.sv
// Shared datapath definitions: skid-pipe state encoding and default word width.
package cpu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/sel_mux_n.sv
// Combinational N-to-1 word select. An out-of-range select falls back to channel 0 and reports index 0.
module sel_mux_n #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    localparam int unsigned SW   = $clog2(N)
) (
    input  logic [N*WIDTH-1:0] in_data_i,
    input  logic [SW-1:0]      sel_i,
    output logic [WIDTH-1:0]   data_o,
    output logic [SW-1:0]      sel_o
);

    // Scan the channels so an unmatched (out-of-range) select keeps the channel-0 default
    always_comb begin
        data_o = in_data_i[WIDTH-1:0];
        sel_o  = '0;
        for (int unsigned i = 1; i < N; i++) begin
            if (32'(sel_i) == i) begin
                data_o = in_data_i[i*WIDTH +: WIDTH];
                sel_o  = sel_i;
            end
        end
    end

endmodule

// File: rtl/sel_mux_pipe.sv
// Registered N-to-1 word select with valid/ready handshake and a 2-entry skid buffer.
// Optional sticky out-of-range select flag enabled by macro SEL_MUX_PIPE_SELCHK_EN.
module sel_mux_pipe
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned N     = 4,
    localparam int unsigned SW   = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SW-1:0]      in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [WIDTH-1:0]   out_data,
    output logic [SW-1:0]      out_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err
);

    pipe_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [SW-1:0]    main_sel_q, main_sel_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SW-1:0]    skid_sel_q, skid_sel_d;

    logic [WIDTH-1:0] mux_data;
    logic [SW-1:0]    mux_sel;
    logic             in_fire;
    logic             out_fire;

    sel_mux_n #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_sel_mux (
        .in_data_i (in_data),
        .sel_i     (in_sel),
        .data_o    (mux_data),
        .sel_o     (mux_sel)
    );

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_data_q;
    assign out_sel   = main_sel_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Next-state and entry movement: flush overrides any handshake in the same cycle
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d     = BUSY;
                        main_data_d = mux_data;
                        main_sel_d  = mux_sel;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_data_d = mux_data;
                        main_sel_d  = mux_sel;
                    end else if (in_fire) begin
                        state_d     = FULL;
                        skid_data_d = mux_data;
                        skid_sel_d  = mux_sel;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d     = BUSY;
                        main_data_d = skid_data_q;
                        main_sel_d  = skid_sel_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and entry registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
        end
    end

`ifdef SEL_MUX_PIPE_SELCHK_EN
    logic sel_err_q;

    // Sticky flag: set by any accepted out-of-range select, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else if (in_fire && (32'(in_sel) >= N)) begin
            sel_err_q <= 1'b1;
        end
    end

    assign sel_err = sel_err_q;
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Self-checking bench for sel_mux_pipe: N=4 instance against a queue model, N=5 instance for select range checks.
module tb_sel_mux_pipe;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // N = 4 instance
    logic [4*W-1:0] a_data;
    logic [1:0]     a_sel, a_os;
    logic           a_iv, a_ir, a_fl, a_ov, a_or, a_err;
    logic [W-1:0]   a_od;

    // N = 5 instance
    logic [5*W-1:0] b_data;
    logic [2:0]     b_sel, b_os;
    logic           b_iv, b_ir, b_fl, b_ov, b_or, b_err;
    logic [W-1:0]   b_od;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [W-1:0] d;
        logic [1:0]   s;
    } ent_t;

    ent_t mq[$];

`ifdef SEL_MUX_PIPE_SELCHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    sel_mux_pipe #(.WIDTH(W), .N(4)) dut4 (
        .clk(clk), .rst(rst), .in_data(a_data), .in_sel(a_sel), .in_valid(a_iv),
        .in_ready(a_ir), .flush(a_fl), .out_data(a_od), .out_sel(a_os),
        .out_valid(a_ov), .out_ready(a_or), .sel_err(a_err)
    );

    sel_mux_pipe #(.WIDTH(W), .N(5)) dut5 (
        .clk(clk), .rst(rst), .in_data(b_data), .in_sel(b_sel), .in_valid(b_iv),
        .in_ready(b_ir), .flush(b_fl), .out_data(b_od), .out_sel(b_os),
        .out_valid(b_ov), .out_ready(b_or), .sel_err(b_err)
    );

    // One clock step; the FIFO model of the N=4 instance advances with the same inputs
    task automatic tick();
        bit   infire, outfire;
        ent_t e;
        logic [W-1:0] ch[4];
        for (int i = 0; i < 4; i++) ch[i] = a_data[i*W +: W];
        infire  = a_iv && (mq.size() < 2) && !rst;
        outfire = a_or && (mq.size() > 0) && !rst;
        e.s = a_sel;
        e.d = ch[a_sel];
        @(posedge clk);
        if (rst) begin
            mq.delete();
        end else begin
            if (outfire) void'(mq.pop_front());
            if (a_fl) mq.delete();
            else if (infire) mq.push_back(e);
        end
        #1;
    endtask

    task automatic set_a_channels();
        for (int i = 0; i < 4; i++) a_data[i*W +: W] = 32'hA0 + 32'(i);
    endtask

    task automatic test_reset();
        rst = 1'b1; a_iv = 1'b1; a_sel = 2'd1; a_fl = 1'b0; a_or = 1'b0;
        b_iv = 1'b0; b_sel = '0; b_fl = 1'b0; b_or = 1'b0; b_data = '0;
        set_a_channels();
        tick(); tick();
        compared++; if (a_ov !== 1'b0) begin mismatched++; $display("FAIL rst_valid got %b want 0", a_ov); end
        compared++; if (a_od !== 32'h0) begin mismatched++; $display("FAIL rst_data got %h want 0", a_od); end
        compared++; if (a_os !== 2'd0) begin mismatched++; $display("FAIL rst_sel got %0d want 0", a_os); end
        compared++; if (a_ir !== 1'b1) begin mismatched++; $display("FAIL rst_ready got %b want 1", a_ir); end
        compared++; if (a_err !== 1'b0 || b_err !== 1'b0) begin mismatched++; $display("FAIL rst_err got %b%b want 00", a_err, b_err); end
        a_iv = 1'b0;
        rst = 1'b0;
        tick();
        compared++; if (a_ov !== 1'b0) begin mismatched++; $display("FAIL rst_noaccept got %b want 0", a_ov); end
    endtask

    task automatic test_single();
        a_sel = 2'd2; a_iv = 1'b1; a_or = 1'b1;
        tick();
        a_iv = 1'b0;
        compared++; if (a_ov !== 1'b1) begin mismatched++; $display("FAIL single_valid got %b want 1", a_ov); end
        compared++; if (a_od !== 32'hA2) begin mismatched++; $display("FAIL single_data got %h want a2", a_od); end
        compared++; if (a_os !== 2'd2) begin mismatched++; $display("FAIL single_sel got %0d want 2", a_os); end
        tick();
        compared++; if (a_ov !== 1'b0) begin mismatched++; $display("FAIL single_empty got %b want 0", a_ov); end
    endtask

    task automatic test_back_to_back();
        a_or = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_sel = 2'(i % 4); a_iv = 1'b1;
            compared++; if (a_ir !== 1'b1) begin mismatched++; $display("FAIL b2b_ready[%0d] got %b want 1", i, a_ir); end
            tick();
            compared++;
            if (a_ov !== 1'b1 || a_od !== 32'hA0 + 32'(i % 4) || a_os !== 2'(i % 4)) begin
                mismatched++;
                $display("FAIL b2b_out[%0d] got v=%b d=%h s=%0d want v=1 d=%h s=%0d", i, a_ov, a_od, a_os, 32'hA0 + 32'(i % 4), i % 4);
            end
        end
        a_iv = 1'b0;
        tick();
        compared++; if (a_ov !== 1'b0) begin mismatched++; $display("FAIL b2b_drain got %b want 0", a_ov); end
    endtask

    task automatic test_stall();
        a_or = 1'b0;
        a_iv = 1'b1; a_sel = 2'd1; tick();
        a_sel = 2'd3; tick();
        a_iv = 1'b0;
        compared++; if (a_ir !== 1'b0) begin mismatched++; $display("FAIL stall_ready got %b want 0", a_ir); end
        compared++; if (a_ov !== 1'b1 || a_od !== 32'hA1) begin mismatched++; $display("FAIL stall_head got v=%b d=%h want v=1 d=a1", a_ov, a_od); end
        a_iv = 1'b1; a_sel = 2'd0;
        tick();
        a_iv = 1'b0;
        compared++; if (a_od !== 32'hA1 || a_os !== 2'd1) begin mismatched++; $display("FAIL stall_hold got d=%h s=%0d want d=a1 s=1", a_od, a_os); end
        a_or = 1'b1;
        tick();
        compared++; if (a_ov !== 1'b1 || a_od !== 32'hA3 || a_os !== 2'd3) begin mismatched++; $display("FAIL stall_second got v=%b d=%h s=%0d want v=1 d=a3 s=3", a_ov, a_od, a_os); end
        compared++; if (a_ir !== 1'b1) begin mismatched++; $display("FAIL stall_reopen got %b want 1", a_ir); end
        tick();
        compared++; if (a_ov !== 1'b0) begin mismatched++; $display("FAIL stall_drain got %b want 0", a_ov); end
    endtask

    task automatic test_flush();
        a_or = 1'b0;
        a_iv = 1'b1; a_sel = 2'd0; tick();
        a_sel = 2'd2; tick();
        a_fl = 1'b1; a_sel = 2'd1;
        tick();
        a_fl = 1'b0; a_iv = 1'b0;
        compared++; if (a_ov !== 1'b0) begin mismatched++; $display("FAIL flush_valid got %b want 0", a_ov); end
        compared++; if (a_ir !== 1'b1) begin mismatched++; $display("FAIL flush_ready got %b want 1", a_ir); end
        a_or = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++; if (a_ov !== 1'b0) begin mismatched++; $display("FAIL flush_ghost[%0d] got %b want 0", i, a_ov); end
        end
    endtask

    task automatic test_sel_range();
        for (int i = 0; i < 5; i++) b_data[i*W +: W] = 32'hB0 + 32'(i);
        b_or = 1'b1; b_iv = 1'b1; b_sel = 3'd4;
        tick();
        compared++; if (b_ov !== 1'b1 || b_od !== 32'hB4 || b_os !== 3'd4) begin mismatched++; $display("FAIL n5_inrange got v=%b d=%h s=%0d want v=1 d=b4 s=4", b_ov, b_od, b_os); end
        compared++; if (b_err !== 1'b0) begin mismatched++; $display("FAIL n5_err_clean got %b want 0", b_err); end
        b_sel = 3'd6;
        tick();
        b_iv = 1'b0;
        compared++; if (b_ov !== 1'b1 || b_od !== 32'hB0 || b_os !== 3'd0) begin mismatched++; $display("FAIL n5_oor got v=%b d=%h s=%0d want v=1 d=b0 s=0", b_ov, b_od, b_os); end
        compared++; if (b_err !== EXP_ERR) begin mismatched++; $display("FAIL n5_err_set got %b want %b", b_err, EXP_ERR); end
        b_fl = 1'b1; tick();
        b_fl = 1'b0; tick();
        compared++; if (b_err !== EXP_ERR) begin mismatched++; $display("FAIL n5_err_sticky got %b want %b", b_err, EXP_ERR); end
        compared++; if (b_ov !== 1'b0) begin mismatched++; $display("FAIL n5_flushed got %b want 0", b_ov); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) a_data[i*W +: W] = $urandom;
            a_sel = 2'($urandom_range(0, 3));
            a_iv  = ($urandom_range(0, 3) != 0);
            a_or  = ($urandom_range(0, 2) != 0);
            a_fl  = ($urandom_range(0, 19) == 0);
            compared++;
            if (a_ir !== (mq.size() < 2) || a_ov !== (mq.size() > 0)) begin
                mismatched++;
                $display("FAIL rand_flags[%0d] got ir=%b ov=%b want occupancy %0d", c, a_ir, a_ov, mq.size());
            end
            if (mq.size() > 0) begin
                compared++;
                if (a_od !== mq[0].d || a_os !== mq[0].s) begin
                    mismatched++;
                    $display("FAIL rand_data[%0d] got d=%h s=%0d want d=%h s=%0d", c, a_od, a_os, mq[0].d, mq[0].s);
                end
            end
            tick();
        end
        a_iv = 1'b0; a_fl = 1'b0; a_or = 1'b1;
        tick(); tick();
        compared++; if (a_ov !== 1'b0 || mq.size() != 0) begin mismatched++; $display("FAIL rand_drain got %b want 0", a_ov); end
        compared++; if (a_err !== 1'b0) begin mismatched++; $display("FAIL n4_err got %b want 0", a_err); end
    endtask

    task automatic test_reset_mid();
        set_a_channels();
        a_or = 1'b0; a_iv = 1'b1;
        a_sel = 2'd1; tick();
        a_sel = 2'd3; tick();
        a_iv = 1'b0;
        rst = 1'b1; a_or = 1'b1;
        tick();
        compared++; if (a_ov !== 1'b0 || a_od !== 32'h0 || a_os !== 2'd0) begin mismatched++; $display("FAIL rstmid_out got v=%b d=%h s=%0d want v=0 d=0 s=0", a_ov, a_od, a_os); end
        compared++; if (a_ir !== 1'b1) begin mismatched++; $display("FAIL rstmid_ready got %b want 1", a_ir); end
        compared++; if (b_err !== 1'b0) begin mismatched++; $display("FAIL rstmid_err got %b want 0", b_err); end
        rst = 1'b0;
        a_sel = 2'd2; a_iv = 1'b1;
        tick();
        a_iv = 1'b0;
        compared++; if (a_ov !== 1'b1 || a_od !== 32'hA2 || a_os !== 2'd2) begin mismatched++; $display("FAIL rstmid_after got v=%b d=%h s=%0d want v=1 d=a2 s=2", a_ov, a_od, a_os); end
        tick();
        compared++; if (a_ov !== 1'b0) begin mismatched++; $display("FAIL rstmid_empty got %b want 0", a_ov); end
    endtask

    initial begin
        a_data = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_flush();
        test_sel_range();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sel_mux_pipe.md
Name: sel_mux_pipe

Overview:
- Parametrised N-to-1 word multiplexer with a registered output stage and a valid/ready handshake.
- A 2-entry skid buffer decouples producer and consumer and sustains one transfer per cycle.
- Generalises the fixed 4:1 32-bit combinational select used for operand and writeback selection in the CPU datapath.
- Sits between pipeline stages where the selected operand must be registered and must tolerate downstream stall and flush.

Parameters:
- WIDTH, 32, data word width in bits.
- N, 4, number of input channels; legal range 2..16.
- SW, $clog2(N), select width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_data  in  N*WIDTH  flattened inputs; channel i at bits [i*WIDTH +: WIDTH].
- in_sel  in  SW  channel select, sampled with in_valid.
- in_valid  in  1  producer has data.
- in_ready  out  1  block can accept.
- flush  in  1  synchronous discard of all held entries.
- out_data  out  WIDTH  selected, registered word.
- out_sel  out  SW  channel index that produced out_data.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts.
- sel_err  out  1  sticky out-of-range select flag (see Optional Feature).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high; all state changes on rising clk only.
- Handshake:
  - Input fire = in_valid & in_ready; output fire = out_valid & out_ready.
  - Selection happens at input fire. Word = channel in_sel; if in_sel >= N, word = channel 0 and out_sel = 0.
  - in_data and in_sel need only be stable in the fire cycle.
  - Latency is 1 cycle: data accepted at edge k is on out_data after edge k.
- Storage:
  - Main register (drives out_*) plus one skid register.
  - in_ready = (state != FULL), decoded from the state flop only; it has no combinational path from out_ready.
- States: EMPTY, BUSY (main full), FULL (main + skid full). out_valid = (state != EMPTY).
- Transitions:
  - EMPTY: in fire -> BUSY, main <= selected word.
  - BUSY, in fire & out fire -> BUSY, main <= new word.
  - BUSY, in fire & !out fire -> FULL, skid <= new word.
  - BUSY, !in fire & out fire -> EMPTY.
  - BUSY, neither -> hold.
  - FULL: out fire -> BUSY, main <= skid. Otherwise hold; out_data and out_sel stay stable while stalled.
- flush:
  - Next state EMPTY; main and skid contents are don't-care.
  - Any input fire in the same cycle is discarded.
  - Any output fire in the same cycle still counts as consumed.
- Priority: rst > flush > handshake.
- Reset values:
  - state EMPTY, out_valid 0, out_data 0, out_sel 0, sel_err 0.
  - in_ready reads 1 during reset, but no transfer is accepted while rst = 1.
- Reset mid-operation: both entries are dropped; no output fire is generated.
- Ordering: strict FIFO; no entry is duplicated or lost except by flush or rst.

Optional Feature:
- Macro SEL_MUX_PIPE_SELCHK_EN.
- Defined:
  - sel_err sets to 1 on any input fire with in_sel >= N.
  - It stays set until rst; flush does not clear it.
  - The same fire still passes channel 0 downstream.
- Undefined: sel_err is tied to 0 and no check logic is built.
- With power-of-two N the check can never fire; the port is kept for a uniform interface.

Decomposition:
- Shared package cpu_pkg: state encoding (EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2) and the default WIDTH constant.
- One natural sub-module, sel_mux_n: a purely combinational N-to-1 select with out-of-range fallback to channel 0, instantiated once at the input.
- Handshake and skid logic stay in the top module.

Test Plan:
- Reset then single transfer: N = 4, WIDTH = 32, channels 0..3 = 0xA0, 0xA1, 0xA2, 0xA3, in_sel = 2, out_ready = 1 -> one cycle later out_valid = 1, out_data = 0xA2, out_sel = 2; then EMPTY.
- Back-to-back streaming: 8 fires with sel = 0,1,2,3,0,1,2,3, out_ready held 1 -> 8 consecutive outputs in order, in_ready never drops.
- Stall fills skid: two fires (sel 1, then 3) with out_ready = 0 -> state FULL, in_ready = 0, out_data = 0xA1 held. Raise out_ready -> 0xA1 then 0xA3 on consecutive cycles.
- Flush while FULL, with in_valid = 1 on the flush cycle -> next cycle out_valid = 0, in_ready = 1, and no later output of the flushed or new word.
- N = 5, in_sel = 6, macro defined -> out_data = channel 0 word, out_sel = 0, sel_err = 1 and still set after a later flush. Macro undefined -> sel_err stays 0.
- rst asserted while FULL -> next cycle out_valid = 0, out_data = 0, in_ready = 1; a fire after reset releases and behaves as in the first scenario.
